// File: rtl/pc_sp_unit.sv
// Program counter / stack pointer address-generation stage.
// Executes the controller's PC and SP strobes and assembles two-byte jump
// targets (low byte captured first, high byte on the load cycle).
// Drives the selected address toward the MAR and keeps sticky bring-up
// error flags.
module pc_sp_unit #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] PC_RESET = '0,
   parameter logic [ADDR_W-1:0] SP_INIT  = {ADDR_W{1'b1}},
   parameter logic [ADDR_W-1:0] SP_LIMIT = {ADDR_W{1'b1}} - ADDR_W'(255)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pc_en,
   input  logic              pc_rw,
   input  logic              pc_ld,
   input  logic              pc_inc,
   input  logic              sp_en,
   input  logic              sp_rw,
   input  logic              sp_ld,
   input  logic [DATA_W-1:0] data_in,
   output logic [ADDR_W-1:0] pc_out,
   output logic [ADDR_W-1:0] sp_out,
   output logic [ADDR_W-1:0] addr_out,
   output logic              jmp_pending,
   output logic              stk_ovf,
   output logic              stk_unf,
   output logic              seq_err
);

   // The jump target is {high byte on the bus, previously captured low byte}.
   // When ADDR_W < 2*DATA_W the upper bits of the high byte are dropped.
   logic [2*DATA_W-1:0] jump_target;
   logic [DATA_W-1:0]   hold_q;

   logic [ADDR_W-1:0]   pc_d;
   logic [ADDR_W-1:0]   sp_d;
   logic [DATA_W-1:0]   hold_d;
   logic                jmp_pending_d;
   logic                stk_ovf_d;
   logic                stk_unf_d;
   logic                seq_err_d;

   assign jump_target = {data_in, hold_q};

   // The MAR sees the stack pointer whenever the SP is enabled, otherwise the PC.
   assign addr_out = sp_en ? sp_out : pc_out;

   // Next-state decode for the PC path (prioritised) and the independent SP path.
   always_comb begin
      // NOTE: every signal gets its hold value first so no path can infer a latch.
      pc_d          = pc_out;
      sp_d          = sp_out;
      hold_d        = hold_q;
      jmp_pending_d = jmp_pending;
      stk_ovf_d     = stk_ovf;
      stk_unf_d     = stk_unf;
      seq_err_d     = seq_err;

      if (pc_en) begin
         if (pc_rw && pc_ld) begin
            // A load without a captured low byte still happens (stale hold
            // value) but is flagged so bring-up can spot the broken sequence.
            pc_d          = jump_target[ADDR_W-1:0];
            jmp_pending_d = 1'b0;
            if (!jmp_pending) begin
               seq_err_d = 1'b1;
            end
         end else if (pc_rw) begin
            hold_d        = data_in;
            jmp_pending_d = 1'b1;
         end else if (pc_inc) begin
            pc_d = pc_out + ADDR_W'(1);
         end
      end

      if (sp_en && sp_rw) begin
         if (sp_ld) begin
            // Pop: pre-increment, refused at the empty-stack position.
            if (sp_out == SP_INIT) begin
               stk_unf_d = 1'b1;
            end else begin
               sp_d = sp_out + ADDR_W'(1);
            end
         end else begin
            // Push: write lands at the current SP, decrement afterwards,
            // refused at the full-stack boundary.
            if (sp_out == SP_LIMIT) begin
               stk_ovf_d = 1'b1;
            end else begin
               sp_d = sp_out - ADDR_W'(1);
            end
         end
      end
   end

   // State registers with synchronous reset overriding all strobes.
   always_ff @(posedge clk) begin
      // NOTE: registered state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         pc_out      <= PC_RESET;
         sp_out      <= SP_INIT;
         hold_q      <= '0;
         jmp_pending <= 1'b0;
         stk_ovf     <= 1'b0;
         stk_unf     <= 1'b0;
         seq_err     <= 1'b0;
      end else begin
         pc_out      <= pc_d;
         sp_out      <= sp_d;
         hold_q      <= hold_d;
         jmp_pending <= jmp_pending_d;
         stk_ovf     <= stk_ovf_d;
         stk_unf     <= stk_unf_d;
         seq_err     <= seq_err_d;
      end
   end

endmodule

// File: tb/tb_pc_sp_unit.sv
// Scoreboard bench for pc_sp_unit. Each directed vector drives one cycle of
// strobes and queues the outputs expected mid-way through that same cycle
// (registers reflect all earlier vectors, addr_out reflects the current
// sp_en). A monitor pops and compares on every falling edge.
module tb_pc_sp_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        pc_en, pc_rw, pc_ld, pc_inc;
   logic        sp_en, sp_rw, sp_ld;
   logic [7:0]  data_in;
   logic [15:0] pc_out, sp_out, addr_out;
   logic        jmp_pending, stk_ovf, stk_unf, seq_err;

   typedef struct {
      string       name;
      logic [15:0] pc;
      logic [15:0] sp;
      logic [3:0]  flags;   // {jmp_pending, stk_ovf, stk_unf, seq_err}
      logic [15:0] addr;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Strobe bundles: {pc_en, pc_rw, pc_ld, pc_inc, sp_en, sp_rw, sp_ld}
   localparam logic [6:0] IDLE     = 7'b000_0000;
   localparam logic [6:0] INC      = 7'b100_1000;
   localparam logic [6:0] CAP      = 7'b110_0000;
   localparam logic [6:0] CAP_INC  = 7'b110_1000;
   localparam logic [6:0] LD       = 7'b111_0000;
   localparam logic [6:0] PC_OFF   = 7'b011_1000;
   localparam logic [6:0] PUSH     = 7'b000_0110;
   localparam logic [6:0] POP      = 7'b000_0111;
   localparam logic [6:0] SPEN     = 7'b000_0100;
   localparam logic [6:0] INC_PUSH = 7'b100_1110;

   localparam logic [3:0] F_NONE = 4'b0000;
   localparam logic [3:0] F_JP   = 4'b1000;
   localparam logic [3:0] F_OVF  = 4'b0100;
   localparam logic [3:0] F_UNF  = 4'b0010;
   localparam logic [3:0] F_SEQ  = 4'b0001;

   pc_sp_unit dut (
      .clk         (clk),
      .reset       (reset),
      .pc_en       (pc_en),
      .pc_rw       (pc_rw),
      .pc_ld       (pc_ld),
      .pc_inc      (pc_inc),
      .sp_en       (sp_en),
      .sp_rw       (sp_rw),
      .sp_ld       (sp_ld),
      .data_in     (data_in),
      .pc_out      (pc_out),
      .sp_out      (sp_out),
      .addr_out    (addr_out),
      .jmp_pending (jmp_pending),
      .stk_ovf     (stk_ovf),
      .stk_unf     (stk_unf),
      .seq_err     (seq_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Drive one cycle of stimulus and queue what the outputs must show during it.
   task automatic step(input string name, input logic rst, input logic [6:0] s,
                       input logic [7:0] d, input logic [15:0] epc, input logic [15:0] esp,
                       input logic [3:0] eflags, input logic [15:0] eaddr);
      exp_t e;
      reset = rst;
      {pc_en, pc_rw, pc_ld, pc_inc, sp_en, sp_rw, sp_ld} = s;
      data_in = d;
      e.name  = name;
      e.pc    = epc;
      e.sp    = esp;
      e.flags = eflags;
      e.addr  = eaddr;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare the queued expectation against the live outputs mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, ".pc"},   pc_out,   e.pc);
            check({e.name, ".sp"},   sp_out,   e.sp);
            check({e.name, ".addr"}, addr_out, e.addr);
            check({e.name, ".jp"},   16'(jmp_pending), 16'(e.flags[3]));
            check({e.name, ".ovf"},  16'(stk_ovf),     16'(e.flags[2]));
            check({e.name, ".unf"},  16'(stk_unf),     16'(e.flags[1]));
            check({e.name, ".seq"},  16'(seq_err),     16'(e.flags[0]));
         end
      end
   end

   initial begin
      int wait_cycles;
      reset = 1'b1;
      {pc_en, pc_rw, pc_ld, pc_inc, sp_en, sp_rw, sp_ld} = IDLE;
      data_in = 8'h00;
      @(posedge clk);
      #1;

      // Increment from reset, addr_out follows the PC.
      step("inc0", 0, INC,  8'h00, 16'h0000, 16'hFFFF, F_NONE, 16'h0000);
      step("inc1", 0, INC,  8'h00, 16'h0001, 16'hFFFF, F_NONE, 16'h0001);
      step("inc2", 0, INC,  8'h00, 16'h0002, 16'hFFFF, F_NONE, 16'h0002);
      step("inc3", 0, IDLE, 8'h00, 16'h0003, 16'hFFFF, F_NONE, 16'h0003);

      // Two-byte jump: low byte captured, then high byte loads.
      step("jcap", 0, CAP,  8'h34, 16'h0003, 16'hFFFF, F_NONE, 16'h0003);
      step("jld",  0, LD,   8'h12, 16'h0003, 16'hFFFF, F_JP,   16'h0003);
      step("jres", 0, IDLE, 8'h00, 16'h1234, 16'hFFFF, F_NONE, 16'h1234);

      // Jump to 0xFFFF then wrap on increment.
      step("wcap", 0, CAP,  8'hFF, 16'h1234, 16'hFFFF, F_NONE, 16'h1234);
      step("wld",  0, LD,   8'hFF, 16'h1234, 16'hFFFF, F_JP,   16'h1234);
      step("winc", 0, INC,  8'h00, 16'hFFFF, 16'hFFFF, F_NONE, 16'hFFFF);
      step("wres", 0, IDLE, 8'h00, 16'h0000, 16'hFFFF, F_NONE, 16'h0000);

      // Capture ignores pc_inc; strobes without pc_en do nothing.
      step("cinc", 0, CAP_INC, 8'hAA, 16'h0000, 16'hFFFF, F_NONE, 16'h0000);
      step("poff", 0, PC_OFF,  8'h55, 16'h0000, 16'hFFFF, F_JP,   16'h0000);
      step("cld",  0, LD,      8'hBB, 16'h0000, 16'hFFFF, F_JP,   16'h0000);
      step("cres", 0, IDLE,    8'h00, 16'hBBAA, 16'hFFFF, F_NONE, 16'hBBAA);

      // Push, push, pop from reset.
      step("rst1",  1, IDLE, 8'h00, 16'hBBAA, 16'hFFFF, F_NONE, 16'hBBAA);
      step("push1", 0, PUSH, 8'h00, 16'h0000, 16'hFFFF, F_NONE, 16'hFFFF);
      step("push2", 0, PUSH, 8'h00, 16'h0000, 16'hFFFE, F_NONE, 16'hFFFE);
      step("pop1",  0, POP,  8'h00, 16'h0000, 16'hFFFD, F_NONE, 16'hFFFD);
      step("spen",  0, SPEN, 8'h00, 16'h0000, 16'hFFFE, F_NONE, 16'hFFFE);
      step("spidl", 0, IDLE, 8'h00, 16'h0000, 16'hFFFE, F_NONE, 16'h0000);

      // Underflow at the empty-stack position.
      step("rst2",  1, IDLE, 8'h00, 16'h0000, 16'hFFFE, F_NONE, 16'h0000);
      step("upop",  0, POP,  8'h00, 16'h0000, 16'hFFFF, F_NONE, 16'hFFFF);
      step("uchk",  0, IDLE, 8'h00, 16'h0000, 16'hFFFF, F_UNF,  16'h0000);

      // Walk SP down to the limit, then overflow.
      for (int i = 0; i < 255; i++) begin
         step($sformatf("fill%0d", i), 0, PUSH, 8'h00, 16'h0000,
              16'hFFFF - 16'(i), F_UNF, 16'hFFFF - 16'(i));
      end
      step("opush", 0, PUSH, 8'h00, 16'h0000, 16'hFF00, F_UNF,         16'hFF00);
      step("ochk",  0, IDLE, 8'h00, 16'h0000, 16'hFF00, F_UNF | F_OVF, 16'h0000);

      // Reset clears the sticky flags.
      step("rst3",  1, IDLE, 8'h00, 16'h0000, 16'hFF00, F_UNF | F_OVF, 16'h0000);
      step("clr",   0, IDLE, 8'h00, 16'h0000, 16'hFFFF, F_NONE,        16'h0000);

      // Load with no captured byte uses hold = 0 and flags seq_err.
      step("sld",   0, LD,   8'h12, 16'h0000, 16'hFFFF, F_NONE, 16'h0000);
      step("schk",  0, IDLE, 8'h00, 16'h1200, 16'hFFFF, F_SEQ,  16'h1200);

      // Reset mid-jump discards the captured byte.
      step("rst4",  1, IDLE, 8'h00, 16'h1200, 16'hFFFF, F_SEQ,  16'h1200);
      step("mcap",  0, CAP,  8'h34, 16'h0000, 16'hFFFF, F_NONE, 16'h0000);
      step("rst5",  1, IDLE, 8'h00, 16'h0000, 16'hFFFF, F_JP,   16'h0000);
      step("mld",   0, LD,   8'h12, 16'h0000, 16'hFFFF, F_NONE, 16'h0000);
      step("mchk",  0, IDLE, 8'h00, 16'h1200, 16'hFFFF, F_SEQ,  16'h1200);

      // Simultaneous increment and push; addr_out selects SP.
      step("both",  0, INC_PUSH, 8'h00, 16'h1200, 16'hFFFF, F_SEQ, 16'hFFFF);
      step("bsp",   0, SPEN,     8'h00, 16'h1201, 16'hFFFE, F_SEQ, 16'hFFFE);
      step("bpc",   0, IDLE,     8'h00, 16'h1201, 16'hFFFE, F_SEQ, 16'h1201);

      // Let the monitor drain the last expectation, bounded.
      wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 10) begin
         @(posedge clk);
         wait_cycles++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d expected=0 pending entries", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
